// File: rtl/hci_core_merge.sv
//==============================================================================
// Module  : hci_core_merge
// Brief   : Gathers NB_IN_CHAN narrow HCI core initiator channels into a
//           single wide HCI core transaction. Each narrow channel owns a
//           1-entry request buffer so lockstep initiators that arrive in
//           different cycles are accepted independently. The wide request
//           issues only once every channel has a request pending. Wide
//           responses are sliced and returned to every channel in the same
//           cycle with zero latency.
//
// Ports   : clk_i, rst_ni (async, active-low), clear_i (sync clear)
//           tcdm_slave_*   : NB_IN_CHAN narrow channels, DW/NB_IN_CHAN data
//           tcdm_master_*  : wide merged channel, DW data
//           err_o          : sticky lane consistency error
//
// Options : define HCI_CORE_MERGE_CHECK_EN to check, on every wide issue,
//           that channel i addresses add[0] + i*BW_IN with the same wen as
//           channel 0. Without the macro err_o is tied low.
//
// Notes   : Narrow-side boffs carries no meaning once lanes are merged and is
//           ignored; the wide boffs is driven to zero.
//
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module hci_core_merge #(
    parameter int DW              = 64,
    parameter int NB_IN_CHAN      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int AW              = 32,
    parameter int BOFFS_W         = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,

    // narrow initiator channels
    input  logic [NB_IN_CHAN-1:0]                      tcdm_slave_req_i,
    output logic [NB_IN_CHAN-1:0]                      tcdm_slave_gnt_o,
    input  logic [NB_IN_CHAN-1:0][AW-1:0]              tcdm_slave_add_i,
    input  logic [NB_IN_CHAN-1:0]                      tcdm_slave_wen_i,
    input  logic [NB_IN_CHAN-1:0][DW/NB_IN_CHAN/8-1:0] tcdm_slave_be_i,
    input  logic [NB_IN_CHAN-1:0][DW/NB_IN_CHAN-1:0]   tcdm_slave_data_i,
    input  logic [NB_IN_CHAN-1:0][BOFFS_W-1:0]         tcdm_slave_boffs_i,
    input  logic [NB_IN_CHAN-1:0]                      tcdm_slave_lrdy_i,
    output logic [NB_IN_CHAN-1:0][DW/NB_IN_CHAN-1:0]   tcdm_slave_r_data_o,
    output logic [NB_IN_CHAN-1:0]                      tcdm_slave_r_valid_o,
    output logic [NB_IN_CHAN-1:0]                      tcdm_slave_r_opc_o,

    // wide merged channel
    output logic                                       tcdm_master_req_o,
    input  logic                                       tcdm_master_gnt_i,
    output logic [AW-1:0]                              tcdm_master_add_o,
    output logic                                       tcdm_master_wen_o,
    output logic [DW/8-1:0]                            tcdm_master_be_o,
    output logic [DW-1:0]                              tcdm_master_data_o,
    output logic [BOFFS_W-1:0]                         tcdm_master_boffs_o,
    output logic                                       tcdm_master_lrdy_o,
    input  logic [DW-1:0]                              tcdm_master_r_data_i,
    input  logic                                       tcdm_master_r_valid_i,
    input  logic                                       tcdm_master_r_opc_i,

    output logic                                       err_o
);

    localparam int DW_IN = DW / NB_IN_CHAN;
    localparam int BW_IN = DW_IN / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NB_IN_CHAN-1:0]             buf_v_q, buf_v_d;
    logic [NB_IN_CHAN-1:0][AW-1:0]     buf_add_q;
    logic [NB_IN_CHAN-1:0]             buf_wen_q;
    logic [NB_IN_CHAN-1:0][BW_IN-1:0]  buf_be_q;
    logic [NB_IN_CHAN-1:0][DW_IN-1:0]  buf_data_q;
    logic [CNT_W-1:0]                  out_cnt_q, out_cnt_d;

    // Effective per-channel request: buffered entry wins over the live port
    logic [NB_IN_CHAN-1:0]             pend;
    logic [NB_IN_CHAN-1:0][AW-1:0]     eff_add;
    logic [NB_IN_CHAN-1:0]             eff_wen;
    logic [NB_IN_CHAN-1:0][BW_IN-1:0]  eff_be;
    logic [NB_IN_CHAN-1:0][DW_IN-1:0]  eff_data;
    logic                              fire;

    for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_eff
        assign pend[i]     = buf_v_q[i] | tcdm_slave_req_i[i];
        assign eff_add[i]  = buf_v_q[i] ? buf_add_q[i]  : tcdm_slave_add_i[i];
        assign eff_wen[i]  = buf_v_q[i] ? buf_wen_q[i]  : tcdm_slave_wen_i[i];
        assign eff_be[i]   = buf_v_q[i] ? buf_be_q[i]   : tcdm_slave_be_i[i];
        assign eff_data[i] = buf_v_q[i] ? buf_data_q[i] : tcdm_slave_data_i[i];
    end

    // -------------------------------------------------------------------------
    // Request path
    // -------------------------------------------------------------------------
    assign tcdm_master_req_o   = (&pend) & (out_cnt_q < MAX_CNT);
    assign fire                = tcdm_master_req_o & tcdm_master_gnt_i;

    // An empty buffer always accepts: the request either goes straight
    // through (fire) or lands in the buffer. A full buffer blocks its channel
    // until the buffered entry has been issued.
    assign tcdm_slave_gnt_o    = tcdm_slave_req_i & ~buf_v_q;

    // Packed channel arrays already place channel 0 in the LSBs.
    assign tcdm_master_add_o   = eff_add[0];
    assign tcdm_master_wen_o   = eff_wen[0];
    assign tcdm_master_be_o    = eff_be;
    assign tcdm_master_data_o  = eff_data;
    assign tcdm_master_boffs_o = '0;
    assign tcdm_master_lrdy_o  = &tcdm_slave_lrdy_i;

    always_comb begin
        buf_v_d = buf_v_q;
        if (fire) begin
            buf_v_d = '0;
        end else begin
            buf_v_d = buf_v_q | tcdm_slave_gnt_o;
        end
    end

    // Responses that were in flight across a clear can still arrive, so the
    // counter refuses to decrement below zero.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (fire && !tcdm_master_r_valid_i) begin
            out_cnt_d = out_cnt_q + ONE_CNT;
        end else if (!fire && tcdm_master_r_valid_i && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_v_q    <= '0;
            buf_add_q  <= '0;
            buf_wen_q  <= '0;
            buf_be_q   <= '0;
            buf_data_q <= '0;
            out_cnt_q  <= '0;
        end else if (clear_i) begin
            buf_v_q    <= '0;
            buf_add_q  <= '0;
            buf_wen_q  <= '0;
            buf_be_q   <= '0;
            buf_data_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            buf_v_q   <= buf_v_d;
            out_cnt_q <= out_cnt_d;
            for (int i = 0; i < NB_IN_CHAN; i++) begin
                // capture only when the accepted request did not go through
                if (tcdm_slave_gnt_o[i] && !fire) begin
                    buf_add_q[i]  <= tcdm_slave_add_i[i];
                    buf_wen_q[i]  <= tcdm_slave_wen_i[i];
                    buf_be_q[i]   <= tcdm_slave_be_i[i];
                    buf_data_q[i] <= tcdm_slave_data_i[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response path: zero-latency broadcast, data sliced per lane
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_rsp
        assign tcdm_slave_r_valid_o[i] = tcdm_master_r_valid_i;
        assign tcdm_slave_r_data_o[i]  = tcdm_master_r_data_i[i*DW_IN +: DW_IN];
        assign tcdm_slave_r_opc_o[i]   = tcdm_master_r_opc_i;
    end

    logic boffs_unused;
    assign boffs_unused = ^tcdm_slave_boffs_i;

    // -------------------------------------------------------------------------
    // Optional lane consistency check
    // -------------------------------------------------------------------------
`ifdef HCI_CORE_MERGE_CHECK_EN
    logic [NB_IN_CHAN-1:0] mismatch;
    logic                  err_q;

    assign mismatch[0] = 1'b0;
    for (genvar i = 1; i < NB_IN_CHAN; i++) begin : g_chk
        assign mismatch[i] = (eff_add[i] != (eff_add[0] + AW'(i * BW_IN))) |
                             (eff_wen[i] != eff_wen[0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else if (fire && (|mismatch)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && fire) begin
            assert (mismatch == '0)
                else $error("hci_core_merge: lane add/wen inconsistency 0x%0h", mismatch);
        end
    end
`endif
`else
    logic chk_unused;
    assign chk_unused = ^{eff_add, eff_wen};
    assign err_o      = 1'b0;
`endif

endmodule

`default_nettype wire
